// File: rtl/seg_pkg.sv
// Shared types and sizes for the seven-segment display arbiter.
// The SEG_BLINK_EN build option (blink ports + timer) is handled in the
// interface and top files; nothing here depends on it.
package seg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } seg_arb_state_t;

    typedef logic [3:0] bcd_t;

    localparam int NUM_DIGITS = 8;
    localparam int unsigned BCD_W = 4;
    localparam int unsigned BUS_W = NUM_DIGITS * BCD_W;
    localparam int unsigned EN_W  = NUM_DIGITS;

    // Counter width for a modulus of n, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seg_display_arbiter_if.sv
// Client/display bundle of the seven-segment arbiter.
// Under SEG_BLINK_EN the per-digit blink masks are added to the bundle.
interface seg_display_arbiter_if;
    import seg_pkg::*;

    logic [1:0]       req;
    logic [BUS_W-1:0] bcd0;
    logic [BUS_W-1:0] bcd1;
    logic [EN_W-1:0]  on0;
    logic [EN_W-1:0]  on1;
    logic [1:0]       gnt;
    logic [BUS_W-1:0] bcd_out;
    logic [EN_W-1:0]  turn_on;
`ifdef SEG_BLINK_EN
    logic [EN_W-1:0]  blink0;
    logic [EN_W-1:0]  blink1;
`endif

`ifdef SEG_BLINK_EN
    // Client side: drives requests and digit data, observes the display.
    modport master (
        output req, bcd0, bcd1, on0, on1, blink0, blink1,
        input  gnt, bcd_out, turn_on
    );

    // Arbiter side.
    modport slave (
        input  req, bcd0, bcd1, on0, on1, blink0, blink1,
        output gnt, bcd_out, turn_on
    );
`else
    // Client side: drives requests and digit data, observes the display.
    modport master (
        output req, bcd0, bcd1, on0, on1,
        input  gnt, bcd_out, turn_on
    );

    // Arbiter side.
    modport slave (
        input  req, bcd0, bcd1, on0, on1,
        output gnt, bcd_out, turn_on
    );
`endif

endinterface

// File: rtl/seg_blink_timer.sv
// Free-running blink phase generator: phase toggles every BLINK_PERIOD cycles.
module seg_blink_timer
    import seg_pkg::*;
#(
    parameter int unsigned BLINK_PERIOD = 8
) (
    input  logic clock,
    input  logic reset,
    output logic phase
);

    localparam int unsigned CNT_W = cnt_width(BLINK_PERIOD);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_PERIOD - 1);

    logic [CNT_W-1:0] cnt;

    // Count one half-phase, then flip the phase and restart.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (cnt == CNT_MAX) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt   <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/seg_display_arbiter.sv
// Round-robin owner arbitration of the 8-digit seven-segment display with a
// minimum hold time; the owner's digits and enables are registered out.
// Build option SEG_BLINK_EN adds per-client blink masks and a blink timer.
module seg_display_arbiter
    import seg_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES  = 16,
    parameter int unsigned BLINK_PERIOD = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    seg_display_arbiter_if.slave  bus
);

    localparam int unsigned HOLD_W = cnt_width(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES - 1);

    // Both periods must be at least one cycle.
    if (HOLD_CYCLES < 1 || BLINK_PERIOD < 1) begin : g_bad_param
        $error("seg_display_arbiter: HOLD_CYCLES and BLINK_PERIOD must be >= 1");
    end

    seg_arb_state_t   state, state_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;
    logic             last, last_nxt;
    logic [1:0]       gnt_q, gnt_nxt;
    logic [BUS_W-1:0] bcd_q, bcd_nxt;
    logic [EN_W-1:0]  on_q, on_nxt;
    logic [EN_W-1:0]  mask0_c, mask1_c;

`ifdef SEG_BLINK_EN
    logic phase;

    seg_blink_timer #(
        .BLINK_PERIOD (BLINK_PERIOD)
    ) u_blink_timer (
        .clock (clock),
        .reset (reset),
        .phase (phase)
    );

    // Digits flagged in a client's blink mask go dark during the on-phase.
    always_comb begin
        mask0_c = bus.blink0 & {EN_W{phase}};
        mask1_c = bus.blink1 & {EN_W{phase}};
    end
`else
    // Without blinking no digit is ever masked.
    always_comb begin
        mask0_c = '0;
        mask1_c = '0;
    end
`endif

    // State, hold timer, tie-break history and the registered display outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            hold_cnt <= '0;
            last     <= 1'b1;
            gnt_q    <= 2'b00;
            bcd_q    <= '0;
            on_q     <= '0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_cnt_nxt;
            last     <= last_nxt;
            gnt_q    <= gnt_nxt;
            bcd_q    <= bcd_nxt;
            on_q     <= on_nxt;
        end
    end

    // Arbitration decision plus the values the outputs take on the next edge.
    always_comb begin
        state_nxt    = state;
        hold_cnt_nxt = hold_cnt;
        last_nxt     = last;
        gnt_nxt      = 2'b00;
        bcd_nxt      = bcd_q;
        on_nxt       = '0;

        case (state)
            IDLE: begin
                case (bus.req)
                    2'b01:   state_nxt = OWN0;
                    2'b10:   state_nxt = OWN1;
                    2'b11:   state_nxt = last ? OWN0 : OWN1;
                    default: state_nxt = IDLE;
                endcase
            end
            OWN0: begin
                if (!bus.req[0]) begin
                    state_nxt = bus.req[1] ? OWN1 : IDLE;
                end else if (bus.req[1] && hold_cnt >= HOLD_MAX) begin
                    state_nxt = OWN1;
                end
            end
            OWN1: begin
                if (!bus.req[1]) begin
                    state_nxt = bus.req[0] ? OWN0 : IDLE;
                end else if (bus.req[0] && hold_cnt >= HOLD_MAX) begin
                    state_nxt = OWN0;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // A fresh owner restarts the hold timer; otherwise it saturates.
        if (state_nxt == OWN0 && state != OWN0) begin
            last_nxt     = 1'b0;
            hold_cnt_nxt = '0;
        end else if (state_nxt == OWN1 && state != OWN1) begin
            last_nxt     = 1'b1;
            hold_cnt_nxt = '0;
        end else if (hold_cnt < HOLD_MAX) begin
            hold_cnt_nxt = hold_cnt + HOLD_W'(1);
        end

        // Display follows the next owner live; with no owner digits blank
        // but the last digit values are kept.
        case (state_nxt)
            OWN0: begin
                gnt_nxt = 2'b01;
                bcd_nxt = bus.bcd0;
                on_nxt  = bus.on0 & ~mask0_c;
            end
            OWN1: begin
                gnt_nxt = 2'b10;
                bcd_nxt = bus.bcd1;
                on_nxt  = bus.on1 & ~mask1_c;
            end
            default: begin
                gnt_nxt = 2'b00;
                on_nxt  = '0;
            end
        endcase
    end

    assign bus.gnt     = gnt_q;
    assign bus.bcd_out = bcd_q;
    assign bus.turn_on = on_q;

endmodule
